// File: rtl/pipelined_adder.sv
// Carry-segmented pipelined adder with a valid/ready handshake. Each stage adds one segment.
// Optional signed-overflow output is enabled by the macro PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int SEGS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SEG_W = WIDTH / SEGS;

  if (SEGS < 1 || (WIDTH % SEGS) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of SEGS");
  end

  logic                        adv;
  logic [SEGS-1:0]             valid_q, valid_d;
  logic [SEGS-1:0]             carry_q, carry_d;
  logic [SEGS-1:0][WIDTH-1:0]  sum_q, sum_d;
  logic [SEGS-1:0][WIDTH-1:0]  a_q, a_d;
  logic [SEGS-1:0][WIDTH-1:0]  b_q, b_d;
  logic [SEGS-1:0][SEG_W:0]    seg_res;

  // Operand bits below the current segment are never read again.
  logic dbg_unused;
  assign dbg_unused = ^{a_q, b_q};

  always_comb begin
    adv     = !valid_q[SEGS-1] || out_ready;
    valid_d = valid_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    seg_res = '0;
    if (adv) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        seg_res[0] = {1'b0, a[SEG_W-1:0]} + {1'b0, b[SEG_W-1:0]} + {{SEG_W{1'b0}}, cin};
        a_d[0]     = a;
        b_d[0]     = b;
        sum_d[0]   = '0;
        sum_d[0][SEG_W-1:0] = seg_res[0][SEG_W-1:0];
        carry_d[0] = seg_res[0][SEG_W];
      end
      // Every later stage adds its own segment on top of the partial sum it inherits.
      for (int k = 1; k < SEGS; k++) begin
        seg_res[k] = {1'b0, a_q[k-1][k*SEG_W +: SEG_W]}
                   + {1'b0, b_q[k-1][k*SEG_W +: SEG_W]}
                   + {{SEG_W{1'b0}}, carry_q[k-1]};
        valid_d[k] = valid_q[k-1];
        a_d[k]     = a_q[k-1];
        b_d[k]     = b_q[k-1];
        sum_d[k]   = sum_q[k-1];
        sum_d[k][k*SEG_W +: SEG_W] = seg_res[k][SEG_W-1:0];
        carry_d[k] = seg_res[k][SEG_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q[SEGS-1];
  assign sum       = sum_q[SEGS-1];
  assign cout      = carry_q[SEGS-1];

`ifdef PIPELINED_ADDER_OVF_EN
  // Operand MSBs travel with the beat, so overflow is derived from the last stage registers.
  assign ovf = (a_q[SEGS-1][WIDTH-1] == b_q[SEGS-1][WIDTH-1]) &&
               (sum_q[SEGS-1][WIDTH-1] != a_q[SEGS-1][WIDTH-1]);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: a 32/4 instance and a 16/1 instance against a queue-based reference.
// ovf is checked only when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a32_in_valid, a32_in_ready, a32_cin, a32_out_valid, a32_out_ready, a32_cout;
  logic [31:0] a32_a, a32_b, a32_sum;
  logic        b16_in_valid, b16_in_ready, b16_cin, b16_out_valid, b16_out_ready, b16_cout;
  logic [15:0] b16_a, b16_b, b16_sum;
`ifdef PIPELINED_ADDER_OVF_EN
  logic        a32_ovf, b16_ovf;
`endif

  pipelined_adder #(.WIDTH(32), .SEGS(4)) dut_a32 (
    .clk(clk), .rst(rst), .in_valid(a32_in_valid), .in_ready(a32_in_ready),
    .a(a32_a), .b(a32_b), .cin(a32_cin), .out_valid(a32_out_valid),
    .out_ready(a32_out_ready), .sum(a32_sum), .cout(a32_cout)
`ifdef PIPELINED_ADDER_OVF_EN
    , .ovf(a32_ovf)
`endif
  );

  pipelined_adder #(.WIDTH(16), .SEGS(1)) dut_b16 (
    .clk(clk), .rst(rst), .in_valid(b16_in_valid), .in_ready(b16_in_ready),
    .a(b16_a), .b(b16_b), .cin(b16_cin), .out_valid(b16_out_valid),
    .out_ready(b16_out_ready), .sum(b16_sum), .cout(b16_cout)
`ifdef PIPELINED_ADDER_OVF_EN
    , .ovf(b16_ovf)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [31:0] sum;
  } exp_t;

  // Reference: plain integer addition truncated to w bits.
  function automatic exp_t ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic c);
    longint unsigned t;
    exp_t r;
    t      = longint'(x) + longint'(y) + longint'(c);
    r.sum  = 32'(t & ((64'd1 << w) - 64'd1));
    r.cout = t[w];
    r.ovf  = (x[w-1] == y[w-1]) && (r.sum[w-1] != x[w-1]);
    return r;
  endfunction

  exp_t q_a[$];
  exp_t q_b[$];
  int   a_pops = 0;
  int   b_acc  = 0;

  logic        a_prev_stall, b_prev_stall;
  logic [31:0] a_prev_sum;
  logic [15:0] b_prev_sum;
  logic        a_prev_cout, b_prev_cout;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q_a.delete();
      a_prev_stall = 1'b0;
    end else begin
      check("a32_in_ready_rule", a32_in_ready, !a32_out_valid || a32_out_ready);
      if (a_prev_stall) begin
        check("a32_hold_valid", a32_out_valid, 1);
        check("a32_hold_sum", a32_sum, a_prev_sum);
        check("a32_hold_cout", a32_cout, a_prev_cout);
      end
      if (a32_out_valid && a32_out_ready) begin
        a_pops++;
        if (q_a.size() == 0) check("a32_extra_beat", 1, 0);
        else begin
          e = q_a.pop_front();
          check("a32_sum", a32_sum, e.sum);
          check("a32_cout", a32_cout, e.cout);
`ifdef PIPELINED_ADDER_OVF_EN
          check("a32_ovf", a32_ovf, e.ovf);
`endif
        end
      end
      if (a32_in_valid && a32_in_ready) q_a.push_back(ref_add(32, a32_a, a32_b, a32_cin));
      a_prev_stall = a32_out_valid && !a32_out_ready;
      a_prev_sum   = a32_sum;
      a_prev_cout  = a32_cout;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q_b.delete();
      b_prev_stall = 1'b0;
    end else begin
      check("b16_in_ready_rule", b16_in_ready, !b16_out_valid || b16_out_ready);
      if (b_prev_stall) begin
        check("b16_hold_sum", b16_sum, b_prev_sum);
        check("b16_hold_cout", b16_cout, b_prev_cout);
      end
      if (b16_out_valid && b16_out_ready) begin
        if (q_b.size() == 0) check("b16_extra_beat", 1, 0);
        else begin
          e = q_b.pop_front();
          check("b16_sum", b16_sum, e.sum[15:0]);
          check("b16_cout", b16_cout, e.cout);
`ifdef PIPELINED_ADDER_OVF_EN
          check("b16_ovf", b16_ovf, e.ovf);
`endif
        end
      end
      if (b16_in_valid && b16_in_ready) begin
        b_acc++;
        q_b.push_back(ref_add(16, {16'h0, b16_a}, {16'h0, b16_b}, b16_cin));
      end
      b_prev_stall = b16_out_valid && !b16_out_ready;
      b_prev_sum   = b16_sum;
      b_prev_cout  = b16_cout;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat to the 32/4 instance and counts edges until it reaches the output.
  task automatic send_wait_a(input logic [31:0] av, input logic [31:0] bv, input logic c,
                             output int n);
    a32_in_valid = 1'b1;
    a32_a = av;
    a32_b = bv;
    a32_cin = c;
    step();
    a32_in_valid = 1'b0;
    n = 1;
    while (!a32_out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int pops0;
    int seen;
    logic [31:0] s0;
    logic        c0;

    rst = 1'b1;
    a32_in_valid = 1'b0; a32_a = '0; a32_b = '0; a32_cin = 1'b0; a32_out_ready = 1'b0;
    b16_in_valid = 1'b0; b16_a = '0; b16_b = '0; b16_cin = 1'b0; b16_out_ready = 1'b1;
    repeat (3) step();
    check("rst_out_valid", a32_out_valid, 0);
    check("rst_sum", a32_sum, 0);
    check("rst_cout", a32_cout, 0);
    check("rst_b16_sum", b16_sum, 0);
    rst = 1'b0;
    check("rst_in_ready", a32_in_ready, 1);
    a32_out_ready = 1'b1;

    send_wait_a(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, n);
    check("ripple_latency", n, 4);
    check("ripple_sum", a32_sum, 32'h0);
    check("ripple_cout", a32_cout, 1);
    repeat (2) step();

    a32_in_valid = 1'b1; a32_a = 32'h00FF_00FF; a32_b = 32'h0001_0001; a32_cin = 1'b0;
    step();
    a32_a = 32'h1234_5678; a32_b = 32'h1111_1111; a32_cin = 1'b1;
    step();
    a32_in_valid = 1'b0;
    repeat (2) step();
    check("b2b_first_valid", a32_out_valid, 1);
    check("b2b_first_sum", a32_sum, 32'h0100_0100);
    check("b2b_first_cout", a32_cout, 0);
    step();
    check("b2b_second_valid", a32_out_valid, 1);
    check("b2b_second_sum", a32_sum, 32'h2345_678A);
    check("b2b_second_cout", a32_cout, 0);
    repeat (2) step();

`ifdef PIPELINED_ADDER_OVF_EN
    send_wait_a(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, n);
    check("ovf_pos_sum", a32_sum, 32'h8000_0000);
    check("ovf_pos_ovf", a32_ovf, 1);
    check("ovf_pos_cout", a32_cout, 0);
    send_wait_a(32'h8000_0000, 32'h8000_0000, 1'b0, n);
    check("ovf_neg_sum", a32_sum, 32'h0);
    check("ovf_neg_ovf", a32_ovf, 1);
    check("ovf_neg_cout", a32_cout, 1);
    repeat (2) step();
`endif

    // Fill the pipeline with out_ready low, hold it, then drain.
    pops0 = a_pops;
    a32_out_ready = 1'b0;
    a32_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a32_a = $urandom; a32_b = $urandom; a32_cin = 1'($urandom_range(0, 1));
      step();
    end
    check("stall_in_ready", a32_in_ready, 0);
    check("stall_out_valid", a32_out_valid, 1);
    s0 = a32_sum;
    c0 = a32_cout;
    for (int i = 0; i < 3; i++) begin
      a32_a = $urandom; a32_b = $urandom;
      step();
      check("stall_frozen_sum", a32_sum, s0);
      check("stall_frozen_cout", a32_cout, c0);
      check("stall_frozen_ready", a32_in_ready, 0);
    end
    a32_in_valid = 1'b0;
    a32_out_ready = 1'b1;
    n = 0;
    while (q_a.size() > 0 && n < 20) begin
      step();
      n++;
    end
    step();
    check("stall_drain_empty", q_a.size(), 0);
    check("stall_beat_count", a_pops - pops0, 4);

    // Reset with three beats in flight.
    a32_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a32_a = $urandom; a32_b = $urandom; a32_cin = 1'b1;
      step();
    end
    a32_in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("flush_out_valid", a32_out_valid, 0);
    check("flush_sum", a32_sum, 0);
    check("flush_cout", a32_cout, 0);
    rst = 1'b0;
    check("flush_in_ready", a32_in_ready, 1);
    seen = 0;
    repeat (10) begin
      step();
      if (a32_out_valid) seen++;
    end
    check("flush_no_stale", seen, 0);

    // Random traffic on the 32/4 instance, biased toward long carry chains.
    for (int i = 0; i < 3000; i++) begin
      a32_in_valid  = ($urandom_range(0, 3) != 0);
      a32_out_ready = ($urandom_range(0, 3) != 0);
      a32_a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      a32_b   = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
      a32_cin = 1'($urandom_range(0, 1));
      step();
    end
    a32_in_valid = 1'b0;
    a32_out_ready = 1'b1;
    n = 0;
    while (q_a.size() > 0 && n < 20) begin
      step();
      n++;
    end
    check("rand_a32_drained", q_a.size(), 0);

    // 16/1 instance: single-cycle latency, then random traffic.
    b16_out_ready = 1'b1;
    b16_in_valid = 1'b1; b16_a = 16'hFFFF; b16_b = 16'h0001; b16_cin = 1'b0;
    step();
    b16_in_valid = 1'b0;
    check("b16_lat1_valid", b16_out_valid, 1);
    check("b16_lat1_sum", b16_sum, 16'h0000);
    check("b16_lat1_cout", b16_cout, 1);
    step();
    b_acc = 0;
    n = 0;
    while (b_acc < 1000 && n < 8000) begin
      b16_in_valid  = ($urandom_range(0, 3) != 0);
      b16_out_ready = ($urandom_range(0, 1) != 0);
      b16_a = 16'($urandom); b16_b = 16'($urandom); b16_cin = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("b16_beat_budget", (b_acc >= 1000), 1);
    b16_in_valid = 1'b0;
    b16_out_ready = 1'b1;
    n = 0;
    while (q_b.size() > 0 && n < 20) begin
      step();
      n++;
    end
    check("rand_b16_drained", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits.
REQ-002 SHALL have parameter SEGS, default 4, number of carry segments and pipeline stages; WIDTH % SEGS == 0, SEGS >= 1, elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  pipeline accepts beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1.

Function
REQ-014 SHALL split operands into SEGS segments of SEG_W = WIDTH/SEGS bits; stage k (0..SEGS-1) adds segment k plus carry registered from stage k-1 (stage 0 uses cin).
REQ-015 SHALL delay not-yet-added upper operand segments and already-computed lower sum segments alongside each beat so segment alignment is preserved.
REQ-016 SHALL give latency of exactly SEGS cycles from accepted input to out_valid with no backpressure.
REQ-017 SHALL sustain one beat per cycle while out_ready is high.
REQ-018 SHALL hold a per-stage valid bit; invalid stages are bubbles and SHALL NOT produce out_valid.
REQ-019 SHALL advance all stages together when adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-020 SHALL hold all stage registers, sum, cout and out_valid unchanged while adv is low.
REQ-021 SHALL, when out_valid, out_ready and in_valid are all high, retire the output beat and accept the new beat in the same cycle.
REQ-022 SHALL ignore a, b, cin when in_valid is low or in_ready is low; a beat is accepted only on in_valid && in_ready.
REQ-023 SHALL keep sum and cout stable while out_valid && !out_ready.
REQ-024 SHALL, for SEGS = 1, behave as a single registered adder with latency 1.

Reset
REQ-025 SHALL clear every stage valid bit and out_valid to 0 on rst, discarding in-flight beats.
REQ-026 SHALL drive sum = 0, cout = 0 and all stage data registers to 0 on rst.
REQ-027 SHALL drive in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, when macro PIPELINED_ADDER_OVF_EN is defined, add port ovf  output  1  signed two's-complement overflow: MSBs of a and b equal and differ from MSB of sum, pipelined with sum, reset to 0.
REQ-029 SHALL, when PIPELINED_ADDER_OVF_EN is undefined, omit the ovf port and its logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: WIDTH=32, SEGS=4, out_ready=1, a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 4 cycles sum=0x00000000, cout=1, full cross-segment carry ripple.
REQ-031 SHALL cover: back-to-back beats (0x00FF00FF+0x00010001, 0x12345678+0x11111111, cin=1 on second) -> consecutive cycles sum=0x01000100 then 0x2345678A, cout=0.
REQ-032 SHALL cover: out_ready low for 3 cycles with pipeline full -> in_ready=0, sum/cout/out_valid frozen; out_ready high -> beats emerge in order, none lost or duplicated.
REQ-033 SHALL cover: rst asserted with 3 beats in flight -> next cycle out_valid=0, sum=0, cout=0; no stale beat emerges afterwards.
REQ-034 SHALL cover: PIPELINED_ADDER_OVF_EN defined, a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, ovf=1, cout=0; a=0x80000000, b=0x80000000 -> sum=0, ovf=1, cout=1.
REQ-035 SHALL cover: WIDTH=16, SEGS=1, 1000 random beats with random out_ready -> every sum/cout matches reference model, latency 1 when unstalled.
